gpll_apb_reconfig: RTL and testbench

APB initiator that drives the GPLL dynamic-reconfiguration port, replacing the all-zero tie-offs on the PLL wrapper's APB pins when a design needs runtime divider, duty or phase changes. It accepts single register read and write commands from a local controller, runs APB setup/access phases, and manages the reconfiguration sequence around write bursts: PLL reset during writes, a hold period, then waiting for relock. It sits between the lab control logic and the GPLL instance; APB_CLK on the GPLL is driven from the same `clk`.

---
 rtl/gpll_apb_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/gpll_apb_reconfig.sv | 161 ++++++++++++++++
 tb/tb_gpll_apb_reconfig.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpll_apb_pkg.sv
// Shared types and constants for the GPLL APB reconfiguration initiator.
//   state_e : controller states
//   ADDR_W  : APB address width
//   DATA_W  : APB data width
//   CNT_W   : width of the shared ACCESS/HOLD/WAIT_LOCK down-counter
package gpll_apb_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp,
    StHold,
    StWaitLock
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, output clears to 0
//   d_i   : asynchronous input
//   q_o   : synchronized output, two destination-clock cycles of latency
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/gpll_apb_reconfig.sv
// APB initiator for the GPLL dynamic-reconfiguration port.
// Runs single APB reads/writes for a local controller and wraps write bursts in
// the PLL restart sequence: pll_rst high from the first write, held RST_HOLD
// cycles after the last write, then released while waiting for relock.
//   clk, rst                      : system/APB clock, async active-high reset
//   cmd_valid/ready/write/last    : command handshake (accepted only in IDLE)
//   cmd_addr, cmd_wdata           : command address and write data
//   rsp_valid, rsp_rdata, rsp_err : one-cycle response pulse
//   apb_*                         : registered APB initiator signals
//   pll_rst, pll_lock, locked     : GPLL reset, raw lock, synchronized lock
//   busy                          : high whenever not IDLE
module gpll_apb_reconfig
  import gpll_apb_pkg::*;
#(
  parameter int unsigned APB_TIMEOUT  = 255,
  parameter int unsigned RST_HOLD     = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_last,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              apb_rst_n,
  output logic              apb_sel,
  output logic              apb_en,
  output logic              apb_write,
  output logic [ADDR_W-1:0] apb_addr,
  output logic [DATA_W-1:0] apb_wdata,
  input  logic [DATA_W-1:0] apb_rdata,
  input  logic              apb_ready,
  output logic              pll_rst,
  input  logic              pll_lock,
  output logic              locked,
  output logic              busy
);

  // Reload values: the counter reaches zero in the last permitted cycle.
  localparam logic [CNT_W-1:0] ApbLoad  = CNT_W'(APB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] LockLoad = CNT_W'(LOCK_TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;

  sync_2ff u_lock_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (pll_lock),
    .q_o   (locked)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      apb_rst_n <= 1'b0;
      apb_sel   <= 1'b0;
      apb_en    <= 1'b0;
      apb_write <= 1'b0;
      apb_addr  <= '0;
      apb_wdata <= '0;
      pll_rst   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      apb_rst_n <= 1'b1;
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // cmd_ready is low for the first cycle after reset release.
          if (cmd_ready && cmd_valid) begin
            state_q   <= StSetup;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            apb_sel   <= 1'b1;
            apb_en    <= 1'b0;
            apb_write <= cmd_write;
            apb_addr  <= cmd_addr;
            apb_wdata <= cmd_wdata;
            last_q    <= cmd_last;
            if (cmd_write) begin
              pll_rst <= 1'b1;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        StSetup: begin
          state_q <= StAccess;
          apb_en  <= 1'b1;
          cnt_q   <= ApbLoad;
        end
        StAccess: begin
          if (apb_ready) begin
            apb_sel <= 1'b0;
            apb_en  <= 1'b0;
            if (apb_write && last_q) begin
              state_q <= StHold;
              cnt_q   <= HoldLoad;
            end else begin
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= apb_write ? '0 : apb_rdata;
            end
          end else if (cnt_q == '0) begin
            // Timed-out writes leave pll_rst high; a later burst recovers.
            apb_sel   <= 1'b0;
            apb_en    <= 1'b0;
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        StHold: begin
          if (cnt_q == '0) begin
            pll_rst <= 1'b0;
            state_q <= StWaitLock;
            cnt_q   <= LockLoad;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWaitLock: begin
          if (locked || (cnt_q == '0)) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_err   <= ~locked;
            rsp_rdata <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpll_apb_reconfig.sv
module tb_gpll_apb_reconfig;

  localparam int APB_TO  = 8;
  localparam int HOLD    = 16;
  localparam int LOCK_TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_last = 1'b0;
  logic [4:0]  cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic        apb_rst_n, apb_sel, apb_en, apb_write;
  logic [4:0]  apb_addr;
  logic [15:0] apb_wdata, apb_rdata;
  logic        apb_ready;
  logic        pll_rst, locked, busy;
  logic        pll_lock = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  // APB slave: register file, ready after slave_wait low ACCESS cycles.
  int          slave_wait = 0;
  int          acc_cnt = 0;
  logic        slave_init = 1'b1;
  logic [15:0] slave_mem [32];
  logic [15:0] model_mem [32];
  logic        exp_rst;

  // Results of the most recent run_cmd.
  int          r_lat, r_fall, r_hi, r_lo, r_acc, r_unstable;
  logic        r_setup_ok, r_err, r_pulse_ok;
  logic [15:0] r_rdata;

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int i);
    return 16'hA5C0 | 16'(i);
  endfunction

  assign apb_ready = apb_sel && apb_en && (acc_cnt >= slave_wait);
  assign apb_rdata = slave_mem[apb_addr];

  always @(posedge clk) begin
    acc_cnt <= (apb_sel && apb_en && !apb_ready) ? acc_cnt + 1 : 0;
    if (slave_init) begin
      for (int i = 0; i < 32; i++) slave_mem[i] <= init_val(i);
    end else if (apb_sel && apb_en && apb_ready && apb_write) begin
      slave_mem[apb_addr] <= apb_wdata;
    end
  end

  gpll_apb_reconfig #(
    .APB_TIMEOUT  (APB_TO),
    .RST_HOLD     (HOLD),
    .LOCK_TIMEOUT (LOCK_TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_last  (cmd_last),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb_rst_n (apb_rst_n),
    .apb_sel   (apb_sel),
    .apb_en    (apb_en),
    .apb_write (apb_write),
    .apb_addr  (apb_addr),
    .apb_wdata (apb_wdata),
    .apb_rdata (apb_rdata),
    .apb_ready (apb_ready),
    .pll_rst   (pll_rst),
    .pll_lock  (pll_lock),
    .locked    (locked),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference latency (accept cycle T to rsp_valid), from the timing rules.
  function automatic int model_latency(input logic w, input logic l, input int wait_c,
                                       input int lock_d);
    int acc;
    int fall;
    if (wait_c >= APB_TO) return 2 + APB_TO;
    acc = wait_c + 1;
    if (!(w && l)) return 2 + acc;
    fall = 2 + acc + HOLD;
    if (lock_d < 0) return fall + LOCK_TO;
    return fall + lock_d + 3;
  endfunction

  // Issue one command and follow it until its response (bounded).
  task automatic run_cmd(input logic w, input logic l, input logic [4:0] a,
                         input logic [15:0] d, input int wait_c, input int lock_d);
    logic prev;
    bit   done;
    int   n;
    slave_wait = wait_c;
    n = 0;
    while (!cmd_ready && n < 200) begin
      step();
      n++;
    end
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_last  = l;
    cmd_addr  = a;
    cmd_wdata = d;
    prev = pll_rst;
    step();
    cmd_valid = 1'b0;
    r_lat = 1; r_fall = -1; r_hi = 0; r_lo = 0; r_acc = 0; r_unstable = 0;
    r_setup_ok = 1'b0;
    done = 1'b0;
    while (!done) begin
      if (r_lat == 1)
        r_setup_ok = apb_sel && !apb_en && (apb_addr == a) && (apb_wdata == d) && (apb_write == w);
      if (pll_rst) r_hi++;
      else r_lo++;
      if (prev && !pll_rst && r_fall < 0) r_fall = r_lat;
      if (r_fall >= 0 && lock_d >= 0 && (r_lat - r_fall) == lock_d) pll_lock = 1'b1;
      if (apb_sel && apb_en) begin
        r_acc++;
        if (apb_addr !== a || apb_wdata !== d || apb_write !== w) r_unstable++;
      end
      if (rsp_valid || r_lat >= 400) begin
        done = 1'b1;
      end else begin
        prev = pll_rst;
        step();
        r_lat++;
      end
    end
    r_rdata = rsp_rdata;
    r_err   = rsp_err;
    step();
    pll_lock = 1'b0;
    r_pulse_ok = !rsp_valid;
  endtask

  task automatic test_reset();
    logic [56:0] outs;
    rst = 1'b1;
    slave_init = 1'b1;
    repeat (3) step();
    outs = {cmd_ready, rsp_valid, rsp_rdata, rsp_err, apb_sel, apb_en, apb_write, apb_addr,
            apb_wdata, pll_rst, locked, busy, apb_rst_n};
    total_cnt++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs);
    else pass_cnt++;
    slave_init = 1'b0;
    rst = 1'b0;
    step();
    total_cnt++;
    if ({cmd_ready, apb_rst_n, busy} !== 3'b110)
      $display("FAIL reset_release: got ready/rst_n/busy %b want 110", {cmd_ready, apb_rst_n, busy});
    else pass_cnt++;
    for (int i = 0; i < 32; i++) model_mem[i] = init_val(i);
    exp_rst = 1'b0;
  endtask

  task automatic test_read_basic();
    run_cmd(1'b0, 1'b0, 5'h03, 16'h1234, 0, -1);
    total_cnt++;
    if (r_lat !== 3) $display("FAIL read_latency: got %0d want 3", r_lat);
    else pass_cnt++;
    total_cnt++;
    if ({r_rdata, r_err} !== {16'hA5C3, 1'b0})
      $display("FAIL read_data: got %h err %b want a5c3 err 0", r_rdata, r_err);
    else pass_cnt++;
    total_cnt++;
    if (r_hi !== 0) $display("FAIL read_pll_rst: got %0d high cycles want 0", r_hi);
    else pass_cnt++;
    total_cnt++;
    if ({r_setup_ok, r_pulse_ok} !== 2'b11)
      $display("FAIL read_setup_pulse: got %b want 11", {r_setup_ok, r_pulse_ok});
    else pass_cnt++;
  endtask

  task automatic test_write_burst();
    logic [4:0]  a [3];
    logic [15:0] d [3];
    for (int k = 0; k < 3; k++) begin
      a[k] = 5'($urandom_range(0, 31));
      d[k] = 16'($urandom);
    end
    for (int k = 0; k < 3; k++) begin
      run_cmd(1'b1, k == 2, a[k], d[k], 0, 10);
      model_mem[a[k]] = d[k];
      if (k < 2) begin
        total_cnt++;
        if (r_lo !== 0 || r_lat !== 3 || pll_rst !== 1'b1)
          $display("FAIL burst_write%0d: got lo %0d lat %0d rst %b want 0 3 1", k, r_lo, r_lat,
                   pll_rst);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (r_fall !== 3 + HOLD) $display("FAIL burst_fall: got %0d want %0d", r_fall, 3 + HOLD);
        else pass_cnt++;
        total_cnt++;
        if (r_lat !== 3 + HOLD + 13)
          $display("FAIL burst_rsp: got %0d want %0d", r_lat, 3 + HOLD + 13);
        else pass_cnt++;
        total_cnt++;
        if ({r_err, r_rdata, pll_rst} !== 18'd0)
          $display("FAIL burst_status: got err %b data %h rst %b want 0 0 0", r_err, r_rdata,
                   pll_rst);
        else pass_cnt++;
      end
    end
    exp_rst = 1'b0;
    run_cmd(1'b0, 1'b0, a[2], 16'h0, 0, -1);
    total_cnt++;
    if (r_rdata !== model_mem[a[2]])
      $display("FAIL burst_readback: got %h want %h", r_rdata, model_mem[a[2]]);
    else pass_cnt++;
  endtask

  task automatic test_wait_states();
    logic [4:0]  a;
    logic [15:0] d;
    a = 5'($urandom_range(0, 31));
    d = 16'($urandom);
    run_cmd(1'b1, 1'b0, a, d, 5, -1);
    model_mem[a] = d;
    exp_rst = 1'b1;
    total_cnt++;
    if (r_acc !== 6 || r_lat !== 8)
      $display("FAIL wait_access: got acc %0d lat %0d want 6 8", r_acc, r_lat);
    else pass_cnt++;
    total_cnt++;
    if (r_unstable !== 0 || r_err !== 1'b0)
      $display("FAIL wait_stable: got unstable %0d err %b want 0 0", r_unstable, r_err);
    else pass_cnt++;
  endtask

  task automatic test_apb_timeout();
    run_cmd(1'b0, 1'b0, 5'($urandom_range(0, 31)), 16'h0, 99, -1);
    total_cnt++;
    if (r_acc !== APB_TO || r_lat !== APB_TO + 2)
      $display("FAIL apb_timeout: got acc %0d lat %0d want %0d %0d", r_acc, r_lat, APB_TO,
               APB_TO + 2);
    else pass_cnt++;
    total_cnt++;
    if ({r_err, cmd_ready, busy, pll_rst} !== 4'b1101)
      $display("FAIL apb_timeout_state: got err/ready/busy/rst %b want 1101",
               {r_err, cmd_ready, busy, pll_rst});
    else pass_cnt++;
  endtask

  task automatic test_lock_timeout();
    logic [4:0]  a;
    logic [15:0] d;
    a = 5'($urandom_range(0, 31));
    d = 16'($urandom);
    run_cmd(1'b1, 1'b1, a, d, 0, -1);
    model_mem[a] = d;
    exp_rst = 1'b0;
    total_cnt++;
    if (r_fall !== 3 + HOLD || r_lat !== 3 + HOLD + LOCK_TO)
      $display("FAIL lock_timeout: got fall %0d lat %0d want %0d %0d", r_fall, r_lat, 3 + HOLD,
               3 + HOLD + LOCK_TO);
    else pass_cnt++;
    total_cnt++;
    if ({r_err, pll_rst} !== 2'b10)
      $display("FAIL lock_timeout_err: got err/rst %b want 10", {r_err, pll_rst});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  a1, a2;
    logic [15:0] got [2];
    int          at [2];
    int          n_rsp;
    int          n;
    logic        addr_ok;
    a1 = 5'($urandom_range(0, 15));
    a2 = 5'($urandom_range(16, 31));
    slave_wait = 0;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_last  = 1'b0;
    cmd_addr  = a1;
    step();
    cmd_addr = a2;  // held valid while busy: must be ignored until IDLE
    n_rsp = 0;
    addr_ok = 1'b0;
    at[0] = -1; at[1] = -1; got[0] = '0; got[1] = '0;
    for (int t = 1; t <= 9; t++) begin
      if (t == 2) addr_ok = (apb_addr == a1);
      if (t == 5) cmd_valid = 1'b0;
      if (rsp_valid) begin
        if (n_rsp < 2) begin
          at[n_rsp]  = t;
          got[n_rsp] = rsp_rdata;
        end
        n_rsp++;
      end
      step();
    end
    total_cnt++;
    if (n_rsp !== 2 || at[0] !== 3 || at[1] !== 7 || !addr_ok)
      $display("FAIL b2b_timing: got n %0d at %0d,%0d addr_ok %b want 2 at 3,7 addr_ok 1", n_rsp,
               at[0], at[1], addr_ok);
    else pass_cnt++;
    total_cnt++;
    if (got[0] !== model_mem[a1] || got[1] !== model_mem[a2])
      $display("FAIL b2b_data: got %h,%h want %h,%h", got[0], got[1], model_mem[a1],
               model_mem[a2]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int   n_rsp;
    logic pre_ok;
    slave_wait = 99;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_last  = 1'b0;
    cmd_addr  = 5'h07;
    cmd_wdata = 16'hBEEF;
    step();
    cmd_valid = 1'b0;
    step();
    pre_ok = apb_sel && apb_en && pll_rst && busy;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (!pre_ok || {apb_sel, apb_en, pll_rst, busy, rsp_valid} !== 5'b0)
      $display("FAIL reset_mid: pre %b got sel/en/rst/busy/rsp %b want 00000", pre_ok,
               {apb_sel, apb_en, pll_rst, busy, rsp_valid});
    else pass_cnt++;
    n_rsp = 0;
    for (int t = 0; t < 2; t++) begin
      step();
      if (rsp_valid) n_rsp++;
    end
    rst = 1'b0;
    slave_wait = 0;
    step();
    if (rsp_valid) n_rsp++;
    total_cnt++;
    if (n_rsp !== 0 || cmd_ready !== 1'b1)
      $display("FAIL reset_mid_release: got rsp %0d ready %b want 0 1", n_rsp, cmd_ready);
    else pass_cnt++;
    exp_rst = 1'b0;
  endtask

  task automatic test_random();
    logic        w, l, to;
    logic [4:0]  a;
    logic [15:0] d, exp_data;
    int          wait_c, lock_d, exp_lat;
    for (int i = 0; i < 30; i++) begin
      w = 1'($urandom_range(0, 1));
      l = w && ($urandom_range(0, 2) == 0);
      a = 5'($urandom_range(0, 31));
      d = 16'($urandom);
      wait_c = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 3);
      lock_d = $urandom_range(0, 6);
      to = (wait_c >= APB_TO);
      exp_lat = model_latency(w, l, wait_c, lock_d);
      exp_data = w ? 16'h0 : model_mem[a];
      run_cmd(w, l, a, d, wait_c, lock_d);
      if (w) exp_rst = 1'b1;
      if (w && l && !to) exp_rst = 1'b0;
      if (w && !to) model_mem[a] = d;
      total_cnt++;
      if (r_lat !== exp_lat || r_err !== to)
        $display("FAIL rand%0d_timing: got lat %0d err %b want %0d %b", i, r_lat, r_err, exp_lat,
                 to);
      else pass_cnt++;
      total_cnt++;
      if (pll_rst !== exp_rst)
        $display("FAIL rand%0d_pll_rst: got %b want %b", i, pll_rst, exp_rst);
      else pass_cnt++;
      if (!to) begin
        total_cnt++;
        if (r_rdata !== exp_data)
          $display("FAIL rand%0d_data: got %h want %h", i, r_rdata, exp_data);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_burst();
    test_wait_states();
    test_apb_timeout();
    test_lock_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
